conv_ctrl: RTL and testbench

//  Sequencer for the 1D convolution computing core. On start, loads KERNEL_LEN taps

---
 rtl/conv_ctrl.sv | 172 +++++++++++++++++
 tb/tb_conv_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequences kernel load, sample streaming and result write-back for the 1D conv core.
// start -> ker_rd_en 1 cycle, -> data_rd_en 1+KERNEL_LEN; CONV_CTRL_ZERO_PAD_EN selects full (padded) convolution.
module conv_ctrl #(
  parameter int DATA_W     = 32,
  parameter int KERNEL_LEN = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   sig_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ker_rd_en,
  output logic [ADDR_W-1:0] ker_addr,
  output logic              data_rd_en,
  output logic [ADDR_W-1:0] data_addr,
  output logic              core_ker_vld,
  output logic              core_din_vld,
  output logic              core_din_zero,
  input  logic              res_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] KL    = CW'(KERNEL_LEN);
  localparam logic [CW-1:0] MAX_N = CW'(1) << ADDR_W;

  if (KERNEL_LEN < 2 || DATA_W < 1) begin : g_param_check
    $error("conv_ctrl: KERNEL_LEN must be >= 2 and DATA_W >= 1");
  end

`ifdef CONV_CTRL_ZERO_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_STREAM, S_PAD, S_DRAIN, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_STREAM, S_DRAIN, S_FINISH} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] n_len, m_len, m_new;
  logic [CW-1:0] out_cnt;
  logic          legal, accept, reject, pad_now, counting;

`ifdef CONV_CTRL_ZERO_PAD_EN
  assign legal = (sig_len != '0) && (sig_len <= MAX_N);
  assign m_new = sig_len + KL - CW'(1);
`else
  assign legal = (sig_len >= KL) && (sig_len <= MAX_N);
  assign m_new = sig_len - KL + CW'(1);
`endif

  always_comb begin
    counting = 1'b0;
    case (state)
      S_STREAM, S_DRAIN: counting = 1'b1;
`ifdef CONV_CTRL_ZERO_PAD_EN
      S_PAD:             counting = 1'b1;
`endif
      default:           counting = 1'b0;
    endcase
  end

  assign out_wr_en = res_valid && counting && (out_cnt < m_len);
  assign out_addr  = out_wr_en ? out_cnt[ADDR_W-1:0] : '0;
  assign ker_addr  = ker_rd_en ? cnt[ADDR_W-1:0] : '0;
  assign data_addr = data_rd_en ? cnt[ADDR_W-1:0] : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ker_rd_en  = 1'b0;
    data_rd_en = 1'b0;
    pad_now    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            accept    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_LOAD_K;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOAD_K: begin
        ker_rd_en = 1'b1;
        if (cnt == KL - CW'(1)) begin
          cnt_nxt   = '0;
          state_nxt = S_STREAM;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_STREAM: begin
        data_rd_en = 1'b1;
        if (cnt == n_len - CW'(1)) begin
          cnt_nxt = '0;
`ifdef CONV_CTRL_ZERO_PAD_EN
          state_nxt = S_PAD;
`else
          state_nxt = S_DRAIN;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef CONV_CTRL_ZERO_PAD_EN
      S_PAD: begin
        pad_now = 1'b1;
        if (cnt == KL - CW'(2)) begin
          cnt_nxt   = '0;
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      S_DRAIN: begin
        // a write landing this cycle completes the set, so leave without an extra wait cycle
        if ((out_cnt == m_len) || (out_wr_en && (out_cnt + CW'(1)) == m_len))
          state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      n_len        <= '0;
      m_len        <= '0;
      out_cnt      <= '0;
      err          <= 1'b0;
      core_ker_vld <= 1'b0;
      core_din_vld <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      err          <= reject;
      // memory read data arrives one cycle after the strobe, so core strobes follow by one
      core_ker_vld <= ker_rd_en;
      core_din_vld <= data_rd_en | pad_now;
      if (accept) begin
        n_len   <= sig_len;
        m_len   <= m_new;
        out_cnt <= '0;
      end else if (out_wr_en) begin
        out_cnt <= out_cnt + CW'(1);
      end
    end
  end

`ifdef CONV_CTRL_ZERO_PAD_EN
  always_ff @(posedge clk) begin
    if (reset) core_din_zero <= 1'b0;
    else       core_din_zero <= pad_now;
  end
`else
  assign core_din_zero = 1'b0;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl with a 2-cycle-latency core model; honours CONV_CTRL_ZERO_PAD_EN.
module tb_conv_ctrl;
  localparam int K  = 4;
  localparam int AW = 10;
`ifdef CONV_CTRL_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, res_valid;
  logic [AW:0]   sig_len;
  logic          busy, done, err, ker_rd_en, data_rd_en;
  logic          core_ker_vld, core_din_vld, core_din_zero, out_wr_en;
  logic [AW-1:0] ker_addr, data_addr, out_addr;

  conv_ctrl #(.DATA_W(32), .KERNEL_LEN(K), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .sig_len(sig_len),
    .busy(busy), .done(done), .err(err),
    .ker_rd_en(ker_rd_en), .ker_addr(ker_addr),
    .data_rd_en(data_rd_en), .data_addr(data_addr),
    .core_ker_vld(core_ker_vld), .core_din_vld(core_din_vld), .core_din_zero(core_din_zero),
    .res_valid(res_valid), .out_wr_en(out_wr_en), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  int exp_ker[$];
  int exp_data[$];
  int exp_out[$];

  int first_ker_cyc, first_data_cyc, last_wr_cyc, done_cyc, start_cyc;
  int done_cnt, zero_cnt, vld_cnt;
  int m_exp, res_emit, din_idx, extra_pend;
  bit extra_en;
  logic [1:0] pipe;
  logic r, gen;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // core model: one result per counted input, two cycles after the input is valid
  initial begin
    res_valid = 1'b0; pipe = '0; extra_pend = 0; res_emit = 0; din_idx = 0;
    m_exp = 0; extra_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset === 1'b1) begin
        pipe = '0; extra_pend = 0; res_valid = 1'b0;
      end else begin
        r = pipe[1];
        if (r) begin
          res_emit++;
          if (extra_en && res_emit == m_exp) extra_pend = 2;
        end else if (extra_pend > 0) begin
          r = 1'b1;
          extra_pend--;
        end
        res_valid = r;
        gen = (core_din_vld === 1'b1) && (PAD || din_idx >= K - 1);
        if (core_din_vld === 1'b1) din_idx++;
        pipe = {pipe[0], gen};
      end
    end
  end

  // monitor: pop expected addresses as strobes are observed
  initial forever begin
    @(negedge clk);
    if (ker_rd_en === 1'b1) begin
      if (first_ker_cyc < 0) first_ker_cyc = cyc;
      if (exp_ker.size() == 0) chk("ker_unexpected", 1, 0);
      else chk("ker_addr", ker_addr, exp_ker.pop_front());
    end
    if (data_rd_en === 1'b1) begin
      if (first_data_cyc < 0) begin
        first_data_cyc = cyc;
        chk("tap_align", core_ker_vld, 1);
      end
      if (exp_data.size() == 0) chk("data_unexpected", 1, 0);
      else chk("data_addr", data_addr, exp_data.pop_front());
    end
    if (out_wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
      else chk("out_addr", out_addr, exp_out.pop_front());
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (core_din_zero === 1'b1) zero_cnt++;
    if (core_din_vld === 1'b1) vld_cnt++;
  end

  task automatic prep(input int n);
    int m;
    m = PAD ? n + K - 1 : n - K + 1;
    for (int i = 0; i < K; i++) exp_ker.push_back(i);
    for (int i = 0; i < n; i++) exp_data.push_back(i % (1 << AW));
    for (int i = 0; i < m; i++) exp_out.push_back(i % (1 << AW));
    m_exp = m; res_emit = 0; din_idx = 0;
    done_cnt = 0; zero_cnt = 0; vld_cnt = 0;
    first_ker_cyc = -1; first_data_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_conv(input int n, input bit restart, input bit extra);
    prep(n);
    extra_en = extra;
    @(posedge clk); #2;
    start = 1'b1; sig_len = n[AW:0]; start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
    if (restart) begin
      for (int i = 0; i < 20 && first_data_cyc < 0; i++) begin
        @(posedge clk); #2;
      end
      repeat (2) begin @(posedge clk); #2; end
      start = 1'b1; sig_len = 11'd5;
      @(posedge clk); #2;
      start = 1'b0;
    end
    for (int i = 0; i < n + 60 && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    chk("done_once", done_cnt, 1);
    chk("ker_latency", first_ker_cyc - start_cyc, 1);
    chk("data_latency", first_data_cyc - start_cyc, 1 + K);
    chk("done_after_last_wr", done_cyc - last_wr_cyc, 1);
    chk("pad_cycles", zero_cnt, PAD ? K - 1 : 0);
    chk("din_vld_cycles", vld_cnt, PAD ? n + K - 1 : n);
    chk("ker_left", exp_ker.size(), 0);
    chk("data_left", exp_data.size(), 0);
    chk("out_left", exp_out.size(), 0);
    chk("idle_busy", busy, 0);
    extra_en = 1'b0;
  endtask

  task automatic try_bad(input int n);
    first_ker_cyc = -1; first_data_cyc = -1;
    @(posedge clk); #2;
    start = 1'b1; sig_len = n[AW:0];
    @(posedge clk); #2;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(posedge clk); #2;
    chk("err_clear", err, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("err_no_read", first_ker_cyc + first_data_cyc, -2);
    chk("err_still_idle", busy, 0);
  endtask

  task automatic abort_run();
    bit hit;
    hit = 1'b0;
    prep(8);
    @(posedge clk); #2;
    start = 1'b1; sig_len = 11'd8;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (data_rd_en === 1'b1 && data_addr == 5) hit = 1'b1;
    end
    chk("abort_reached", hit, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_outs", {done, err, ker_rd_en, data_rd_en, out_wr_en,
                       core_ker_vld, core_din_vld, core_din_zero}, 0);
    chk("abort_addrs", {ker_addr, data_addr, out_addr}, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    exp_ker.delete(); exp_data.delete(); exp_out.delete();
    repeat (4) @(posedge clk);
    #2;
    chk("abort_no_done", done_cnt, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sig_len = '0;
    first_ker_cyc = -1; first_data_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    done_cnt = 0; zero_cnt = 0; vld_cnt = 0; start_cyc = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, err, ker_rd_en, data_rd_en, out_wr_en,
                     core_ker_vld, core_din_vld, core_din_zero}, 0);
    chk("rst_addrs", {ker_addr, data_addr, out_addr}, 0);

    run_conv(8, 1'b0, 1'b0);
    try_bad(PAD ? 0 : 3);
    try_bad((1 << AW) + 1);
    run_conv(8, 1'b1, 1'b1);
    abort_run();
    run_conv(6, 1'b0, 1'b0);
    run_conv(PAD ? 1 : K, 1'b0, 1'b0);
    run_conv(1 << AW, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog expired");
  end
endmodule
